// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider.
// Default operand width, FSM states and counter sizing.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  // Counter must hold the values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CW = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_ripple_subtractor.sv
// N-bit ripple subtractor: a + ~b + 1 through a full-adder chain.
// carry_out high means no borrow (a >= b).
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         carry_out
);

  logic [N:0]   c;
  logic [N-1:0] nb;

  assign nb   = ~b;
  assign c[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_fa
      assign diff[i] = a[i] ^ nb[i] ^ c[i];
      assign c[i+1]  = (a[i] & nb[i])
                     | (c[i] & (a[i] ^ nb[i]));
    end
  endgenerate

  assign carry_out = c[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit
// per clock, with one-cycle done pulse and held results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t state;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] p;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   p_sel;
  logic             no_borrow;
  logic [WIDTH-1:0] q_nx;
  logic             last;
  logic             unused_msb;

  // Shift the next dividend bit into the partial remainder.
  assign p_sh = {p, dvd_sh[WIDTH-1]};

  ripple_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a         (p_sh),
    .b         ({1'b0, dvs}),
    .diff      (trial),
    .carry_out (no_borrow)
  );

  // Restore on borrow; the kept remainder always fits WIDTH bits.
  assign p_sel      = no_borrow ? trial : p_sh;
  assign unused_msb = p_sel[WIDTH];
  assign q_nx       = {q_sh[WIDTH-2:0], no_borrow};
  assign last       = (cnt == CW'(WIDTH - 1));

  // Divider FSM, datapath shift registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_sh      <= '0;
      dvs         <= '0;
      q_sh        <= '0;
      p           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_sh <= dividend;
            dvs    <= divisor;
            p      <= '0;
            q_sh   <= '0;
            cnt    <= '0;
            if (divisor != '0) begin
              state       <= RUN;
              busy        <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p      <= p_sel[WIDTH-1:0];
          q_sh   <= q_nx;
          dvd_sh <= dvd_sh << 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nx;
            remainder <= p_sel[WIDTH-1:0];
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=4.
// Stimulus pushes expected results; a monitor pops on done.
module tb_seq_divider;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t expq[$];
  int   total;
  int   bad;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the queue.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done q=%0d r=%0d z=%0d t=%0t",
                 quotient, remainder, div_by_zero, $time);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.z));
      end
    end
  end

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] eq,
                     input logic [W-1:0] er,
                     input logic         ez);
    int n;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    expq.push_back('{eq, er, ez});
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n);
    chk("latency", n, (b == 0) ? 1 : W + 1);
    chk("busy_at_done", int'(busy), 0);
  endtask

  task automatic hold(input logic [W-1:0] eq,
                      input logic [W-1:0] er,
                      input logic         ez);
    @(negedge clk);
    chk("hold_done", int'(done), 0);
    chk("hold_q", int'(quotient), int'(eq));
    chk("hold_r", int'(remainder), int'(er));
    chk("hold_z", int'(div_by_zero), int'(ez));
  endtask

  initial begin
    int n;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_z", int'(div_by_zero), 0);
    rst   = 1'b0;
    start = 1'b0;

    // 13/3 with cycle-by-cycle busy profile
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    expq.push_back('{4'd4, 4'd1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk("busy_13_3", int'(busy), 1);
      chk("nodone_13_3", int'(done), 0);
      @(negedge clk);
    end
    chk("done_13_3", int'(done), 1);
    chk("busy_end_13_3", int'(busy), 0);
    hold(4'd4, 4'd1, 1'b0);

    // Directed vectors
    run(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run(4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
    run(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    run(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    hold(4'd15, 4'd9, 1'b1);

    // Start during RUN is ignored
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd4;
    expq.push_back('{4'd3, 4'd2, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    @(negedge clk);
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    wait_done(3, n);
    chk("latency_ignore", n, W + 1);
    hold(4'd3, 4'd2, 1'b0);
    hold(4'd3, 4'd2, 1'b0);

    // Reset at the second RUN edge aborts 13/3
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_z", int'(div_by_zero), 0);
    repeat (8) @(negedge clk);
    run(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

    // Back-to-back: start held through DONE
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd10;
    divisor  = 4'd3;
    expq.push_back('{4'd3, 4'd1, 1'b0});
    @(negedge clk);
    wait_done(1, n);
    chk("latency_b2b_1", n, W + 1);
    dividend = 4'd12;
    divisor  = 4'd5;
    expq.push_back('{4'd2, 4'd2, 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_gap_done", int'(done), 0);
    chk("b2b_gap_busy", int'(busy), 1);
    wait_done(1, n);
    chk("latency_b2b_2", n, W + 1);
    hold(4'd2, 4'd2, 1'b0);

    // Exhaustive sweep against an arithmetic model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 4'hf;
          mr = 4'(a);
        end else begin
          mq = 4'(a / b);
          mr = 4'(a % b);
        end
        run(4'(a), 4'(b), mq, mr, (b == 0));
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
